// File: rtl/ncpu32k_immu_assoc_if.sv
// ncpu32k_immu_assoc_if: fetch-address handshake between the IFU, the IMMU and the icache.
// The master side is the IFU/icache pair; the slave side is the IMMU itself.
interface ncpu32k_immu_assoc_if;
    logic        ibus_AREADY;
    logic        ibus_AVALID;
    logic [31:0] ibus_AADDR;
    logic        icache_AREADY;
    logic        icache_AVALID;
    logic [31:0] icache_AADDR;
    logic [1:0]  icache_AEXC;

    modport master (
        output ibus_AVALID, ibus_AADDR, icache_AREADY,
        input  ibus_AREADY, icache_AVALID, icache_AADDR, icache_AEXC
    );

    modport slave (
        input  ibus_AVALID, ibus_AADDR, icache_AREADY,
        output ibus_AREADY, icache_AVALID, icache_AADDR, icache_AEXC
    );
endinterface

// File: rtl/ncpu32k_immu_assoc.sv
// ncpu32k_immu_assoc: N-way set-associative instruction MMU with a one-stage result buffer,
// software-refilled ITLB, hardware flush and optional ASID tagging.
// Optional feature macro: NCPU_IMMU_ASID_EN (adds msr_imm_asid and ASID/G matching).
module ncpu32k_immu_assoc #(
    parameter int          CONFIG_ITLB_NSETS_LOG2 = 7,
    parameter int          CONFIG_ITLB_NWAYS_LOG2 = 1,
    parameter int          CONFIG_PIPEBUF_BYPASS  = 1,
    parameter logic [31:0] CONFIG_EITM_VECTOR     = 32'h0000_0100,
    parameter logic [31:0] CONFIG_EIPF_VECTOR     = 32'h0000_0200,
    localparam int         IW = CONFIG_ITLB_NSETS_LOG2 + CONFIG_ITLB_NWAYS_LOG2
) (
    input  logic                clk,
    input  logic                rst_n,
    ncpu32k_immu_assoc_if.slave bus,
    input  logic                msr_psr_imme,
    input  logic                msr_psr_rm,
`ifdef NCPU_IMMU_ASID_EN
    input  logic [7:0]          msr_imm_asid,
`endif
    output logic [31:0]         msr_immid,
    output logic [31:0]         msr_imm_tlbl,
    output logic [31:0]         msr_imm_tlbh,
    input  logic [IW-1:0]       msr_imm_tlbl_idx,
    input  logic [IW-1:0]       msr_imm_tlbh_idx,
    input  logic [31:0]         msr_imm_tlbl_nxt,
    input  logic [31:0]         msr_imm_tlbh_nxt,
    input  logic                msr_imm_tlbl_we,
    input  logic                msr_imm_tlbh_we,
    input  logic                msr_imm_flush,
    output logic                msr_imm_flush_busy
);
    localparam int S     = CONFIG_ITLB_NSETS_LOG2;
    localparam int NWAYS = 1 << CONFIG_ITLB_NWAYS_LOG2;
    localparam int NSETS = 1 << S;
    localparam int NENT  = NWAYS * NSETS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

`ifdef NCPU_IMMU_ASID_EN
    localparam logic ASID_EN = 1'b1;
`else
    localparam logic ASID_EN = 1'b0;
`endif

    logic [1:0]            state;
    logic [NENT-1:0]       v_q;
    logic [31:1]           tlbl_q [NENT];
    logic [31:0]           tlbh_q [NENT];
    logic                  out_vld;
    logic [31:0]           out_addr;
    logic [1:0]            out_exc;
    logic [NWAYS-1:0]      hit;
    logic [NWAYS-1:0][31:0] way_tlbh;
    logic                  sel_hit;
    logic [31:0]           sel_h;
    logic [31:0]           nxt_addr;
    logic [1:0]            nxt_exc;

    wire [31:0]  va     = bus.ibus_AADDR;
    wire [S-1:0] va_set = va[13+S-1:13];
    wire         busy   = (state != S_IDLE);
    wire         accept = bus.ibus_AVALID & bus.ibus_AREADY;

    assign msr_imm_flush_busy = busy;
    assign bus.ibus_AREADY    = ~busy & (~out_vld | ((CONFIG_PIPEBUF_BYPASS != 0) & bus.icache_AREADY));
    assign bus.icache_AVALID  = out_vld;
    assign bus.icache_AADDR   = out_addr;
    assign bus.icache_AEXC    = out_exc;

    assign msr_immid    = {25'b0, ASID_EN, 3'(CONFIG_ITLB_NWAYS_LOG2), 3'(CONFIG_ITLB_NSETS_LOG2)};
    assign msr_imm_tlbl = {tlbl_q[msr_imm_tlbl_idx], v_q[msr_imm_tlbl_idx]};
    assign msr_imm_tlbh = tlbh_q[msr_imm_tlbh_idx];

    // Per-way tag match; a same-cycle MSR write to the probed entry is forwarded into the lookup.
    for (genvar w = 0; w < NWAYS; w++) begin : g_way
        localparam logic [IW-1:0] WBASE = IW'(w * NSETS);
        wire [IW-1:0] ent = WBASE | IW'(va_set);
        wire          byl = msr_imm_tlbl_we & (msr_imm_tlbl_idx == ent);
        wire          byh = msr_imm_tlbh_we & (msr_imm_tlbh_idx == ent);
        wire [31:0]   l   = byl ? msr_imm_tlbl_nxt : {tlbl_q[ent], v_q[ent]};
        wire          unused_l = ^l[12:1];
        assign way_tlbh[w] = byh ? msr_imm_tlbh_nxt : tlbh_q[ent];
`ifdef NCPU_IMMU_ASID_EN
        assign hit[w] = l[0] & (l[31:13] == va[31:13]) & (l[1] | (l[9:2] == msr_imm_asid));
`else
        assign hit[w] = l[0] & (l[31:13] == va[31:13]);
`endif
    end

    // Lowest hitting way wins.
    always_comb begin
        sel_hit = 1'b0;
        sel_h   = '0;
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (hit[w]) begin
                sel_hit = 1'b1;
                sel_h   = way_tlbh[w];
            end
        end
    end

    wire unused_h = ^{sel_h[12:5], sel_h[2:0]};

    // Translation result for the address being accepted this cycle.
    always_comb begin
        nxt_exc  = 2'b00;
        nxt_addr = va;
        if (msr_psr_imme) begin
            if (!sel_hit) begin
                nxt_exc  = 2'b01;
                nxt_addr = CONFIG_EITM_VECTOR;
            end else if (msr_psr_rm ? ~sel_h[4] : ~sel_h[3]) begin
                nxt_exc  = 2'b10;
                nxt_addr = CONFIG_EIPF_VECTOR;
            end else begin
                nxt_addr = {sel_h[31:13], va[12:0]};
            end
        end
    end

    // Result buffer: load on accept, drop on icache handshake, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_addr <= '0;
            out_exc  <= '0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_addr <= nxt_addr;
            out_exc  <= nxt_exc;
        end else if (bus.icache_AREADY) begin
            out_vld  <= 1'b0;
        end
    end

    // Valid bits: resettable, cleared wholesale by the flush (which overrides a concurrent write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v_q <= '0;
        else if (state == S_CLEAR)
            v_q <= '0;
        else if (msr_imm_tlbl_we)
            v_q[msr_imm_tlbl_idx] <= msr_imm_tlbl_nxt[0];
    end

    // Tag/data storage, no reset needed since V gates every use.
    always_ff @(posedge clk) begin
        if (msr_imm_tlbl_we)
            tlbl_q[msr_imm_tlbl_idx] <= msr_imm_tlbl_nxt[31:1];
        if (msr_imm_tlbh_we)
            tlbh_q[msr_imm_tlbh_idx] <= msr_imm_tlbh_nxt;
    end

    // Flush sequencer: stop accepting, drain the pending result, then clear all V bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else begin
            case (state)
                S_IDLE:  if (msr_imm_flush) state <= S_DRAIN;
                S_DRAIN: if (~out_vld | bus.icache_AREADY) state <= S_CLEAR;
                default: state <= S_IDLE;
            endcase
        end
    end

    a_multi_hit: assert property (@(posedge clk) disable iff (!rst_n)
        !(accept && msr_psr_imme && ($countones(hit) > 1)));

endmodule

// File: tb/tb_ncpu32k_immu_assoc.sv
// tb_ncpu32k_immu_assoc: directed scenarios plus randomized traffic, all checked every cycle
// against an array-based ITLB model indexed by [way][set].
module tb_ncpu32k_immu_assoc;
    localparam int S = 7, NW = 2, NS = 128, IW = 8;
    localparam logic [31:0] EITM = 32'h0000_0100, EIPF = 32'h0000_0200;
`ifdef NCPU_IMMU_ASID_EN
    localparam logic [31:0] IMMID = 32'h0000_004F;
`else
    localparam logic [31:0] IMMID = 32'h0000_000F;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ncpu32k_immu_assoc_if bus();
    logic          imme, rm, l_we, h_we, flush, busy;
    logic [31:0]   immid, tlbl, tlbh, l_nxt, h_nxt;
    logic [IW-1:0] l_idx, h_idx;
`ifdef NCPU_IMMU_ASID_EN
    logic [7:0]    asid;
`endif

    ncpu32k_immu_assoc dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .msr_psr_imme(imme), .msr_psr_rm(rm),
`ifdef NCPU_IMMU_ASID_EN
        .msr_imm_asid(asid),
`endif
        .msr_immid(immid), .msr_imm_tlbl(tlbl), .msr_imm_tlbh(tlbh),
        .msr_imm_tlbl_idx(l_idx), .msr_imm_tlbh_idx(h_idx),
        .msr_imm_tlbl_nxt(l_nxt), .msr_imm_tlbh_nxt(h_nxt),
        .msr_imm_tlbl_we(l_we), .msr_imm_tlbh_we(h_we),
        .msr_imm_flush(flush), .msr_imm_flush_busy(busy)
    );

    int vectors = 0, miscompares = 0;

    // Model state
    logic [31:0] ml [NW][NS];
    logic [31:0] mh [NW][NS];
    bit          wl [NW][NS];
    bit          wh [NW][NS];
    bit          m_valid, m_drain, m_clear;
    logic [31:0] m_addr;
    logic [1:0]  m_exc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !(m_drain || m_clear) && (!m_valid || bus.icache_AREADY);
    endfunction

    function automatic void lookup(input logic [31:0] va, input bit en, input bit kern,
                                   output logic [31:0] a, output logic [1:0] e);
        int s;
        bit found;
        logic [31:0] h;
        s = int'((va >> 13) % NS);
        a = va;
        e = 2'b00;
        found = 0;
        h = '0;
        if (!en) return;
        for (int w = 0; w < NW; w++)
            if (!found && ml[w][s][0] && ml[w][s][31:13] == va[31:13]
`ifdef NCPU_IMMU_ASID_EN
                && (ml[w][s][1] || ml[w][s][9:2] == asid)
`endif
               ) begin
                found = 1;
                h = mh[w][s];
            end
        if (!found) begin a = EITM; e = 2'b01; end
        else if (kern ? !h[4] : !h[3]) begin a = EIPF; e = 2'b10; end
        else a = {h[31:13], va[12:0]};
    endfunction

    task automatic check();
        int lw, ls, hw, hs;
        lw = int'(l_idx) / NS; ls = int'(l_idx) % NS;
        hw = int'(h_idx) / NS; hs = int'(h_idx) % NS;
        chk("icache_avalid", 32'(bus.icache_AVALID), 32'(m_valid));
        chk("flush_busy", 32'(busy), 32'(m_drain || m_clear));
        chk("ibus_aready", 32'(bus.ibus_AREADY), 32'(m_ready()));
        if (m_valid) begin
            chk("icache_aaddr", bus.icache_AADDR, m_addr);
            chk("icache_aexc", 32'(bus.icache_AEXC), 32'(m_exc));
        end
        if (wl[lw][ls]) chk("tlbl_read", tlbl, ml[lw][ls]);
        else            chk("tlbl_v", 32'(tlbl[0]), 32'(ml[lw][ls][0]));
        if (wh[hw][hs]) chk("tlbh_read", tlbh, mh[hw][hs]);
    endtask

    // Advance one clock: model next state from current inputs, then compare after the edge.
    task automatic step();
        bit acc, nv, nd, nc;
        logic [31:0] na;
        logic [1:0] ne;
        acc = bus.ibus_AVALID && m_ready();
        if (l_we) begin ml[int'(l_idx) / NS][int'(l_idx) % NS] = l_nxt; wl[int'(l_idx) / NS][int'(l_idx) % NS] = 1; end
        if (h_we) begin mh[int'(h_idx) / NS][int'(h_idx) % NS] = h_nxt; wh[int'(h_idx) / NS][int'(h_idx) % NS] = 1; end
        if (m_clear)
            for (int w = 0; w < NW; w++) for (int s = 0; s < NS; s++) ml[w][s][0] = 1'b0;
        nv = m_valid; na = m_addr; ne = m_exc;
        if (acc) begin
            nv = 1;
            lookup(bus.ibus_AADDR, imme, rm, na, ne);
        end else if (bus.icache_AREADY) nv = 0;
        nc = m_drain && (!m_valid || bus.icache_AREADY);
        nd = m_drain ? !nc : (!m_clear && flush);
        @(posedge clk); #1;
        m_valid = nv; m_addr = na; m_exc = ne; m_drain = nd; m_clear = nc;
        check();
    endtask

    task automatic model_reset();
        m_valid = 0; m_drain = 0; m_clear = 0; m_addr = '0; m_exc = '0;
        for (int w = 0; w < NW; w++) for (int s = 0; s < NS; s++) ml[w][s][0] = 1'b0;
    endtask

    initial begin
        bit [18:0] tv;
        int w, s;
        bus.ibus_AVALID = 0; bus.ibus_AADDR = '0; bus.icache_AREADY = 1;
        imme = 0; rm = 0; l_we = 0; h_we = 0; flush = 0;
        l_idx = '0; h_idx = '0; l_nxt = '0; h_nxt = '0;
`ifdef NCPU_IMMU_ASID_EN
        asid = '0;
`endif
        for (int i = 0; i < NW; i++) for (int j = 0; j < NS; j++) begin
            wl[i][j] = 0; wh[i][j] = 0; ml[i][j] = '0; mh[i][j] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_avalid", 32'(bus.icache_AVALID), 32'd0);
        chk("rst_aaddr", bus.icache_AADDR, 32'd0);
        chk("rst_aexc", 32'(bus.icache_AEXC), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("immid", immid, IMMID);

        // Pass-through with translation off
        bus.ibus_AVALID = 1; bus.ibus_AADDR = 32'h0000_4ABC;
        step();
        chk("t1_valid", 32'(bus.icache_AVALID), 32'd1);
        chk("t1_addr", bus.icache_AADDR, 32'h0000_4ABC);
        chk("t1_exc", 32'(bus.icache_AEXC), 32'd0);

        // Way1/set5 written in the same cycle as the lookup
        imme = 1; rm = 1; bus.ibus_AADDR = 32'h0000_A010;
        l_we = 1; l_idx = 8'h85; l_nxt = 32'h0000_A001;
        h_we = 1; h_idx = 8'h85; h_nxt = 32'h0000_E010;
        step();
        l_we = 0; h_we = 0;
        chk("t2_addr", bus.icache_AADDR, 32'h0000_E010);
        chk("t2_exc", 32'(bus.icache_AEXC), 32'd0);
        chk("t2_tlbl_rd", tlbl, 32'h0000_A001);
        chk("t2_tlbh_rd", tlbh, 32'h0000_E010);

        // User mode without UX, then an invalidated entry
        rm = 0;
        step();
        chk("t3_pf_exc", 32'(bus.icache_AEXC), 32'd2);
        chk("t3_pf_addr", bus.icache_AADDR, EIPF);
        bus.ibus_AVALID = 0; l_we = 1; l_nxt = 32'h0000_A000;
        step();
        l_we = 0; bus.ibus_AVALID = 1; rm = 1;
        step();
        chk("t3_miss_exc", 32'(bus.icache_AEXC), 32'd1);
        chk("t3_miss_addr", bus.icache_AADDR, EITM);
        bus.ibus_AVALID = 0; l_we = 1; l_nxt = 32'h0000_A001;
        step();
        l_we = 0;

        // Backpressure: result held, nothing accepted, bypass accept on release
        imme = 0; bus.icache_AREADY = 0; bus.ibus_AVALID = 1; bus.ibus_AADDR = 32'h1111_1000;
        step();
        bus.ibus_AADDR = 32'h2222_2000;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_addr", bus.icache_AADDR, 32'h1111_1000);
            chk("t4_ibus_ready", 32'(bus.ibus_AREADY), 32'd0);
        end
        bus.icache_AREADY = 1; #1;
        chk("t4_release_ready", 32'(bus.ibus_AREADY), 32'd1);
        step();
        chk("t4_next_addr", bus.icache_AADDR, 32'h2222_2000);
        bus.ibus_AVALID = 0;
        step();

        // Flush with a result pending
        imme = 1; rm = 1; bus.ibus_AADDR = 32'h0000_A010; bus.ibus_AVALID = 1; bus.icache_AREADY = 0;
        step();
        chk("t5_hit_addr", bus.icache_AADDR, 32'h0000_E010);
        bus.ibus_AVALID = 0; flush = 1;
        step();
        flush = 0;
        chk("t5_busy", 32'(busy), 32'd1);
        chk("t5_ibus_ready", 32'(bus.ibus_AREADY), 32'd0);
        step();
        chk("t5_drain_busy", 32'(busy), 32'd1);
        bus.icache_AREADY = 1;
        step();
        chk("t5_clear_busy", 32'(busy), 32'd1);
        step();
        chk("t5_done_busy", 32'(busy), 32'd0);
        bus.ibus_AVALID = 1;
        step();
        chk("t5_miss_exc", 32'(bus.icache_AEXC), 32'd1);
        bus.ibus_AVALID = 0;
        step();

`ifdef NCPU_IMMU_ASID_EN
        // ASID mismatch misses, global entry hits
        asid = 8'd4; bus.ibus_AVALID = 1; l_we = 1; l_idx = 8'h85; l_nxt = 32'h0000_A00D;
        step();
        chk("t6_asid_miss", 32'(bus.icache_AEXC), 32'd1);
        l_nxt = 32'h0000_A00F;
        step();
        l_we = 0;
        chk("t6_global_exc", 32'(bus.icache_AEXC), 32'd0);
        chk("t6_global_addr", bus.icache_AADDR, 32'h0000_E010);
        bus.ibus_AVALID = 0;
        step();
`endif

        // Reset in the middle of a flush
        l_we = 1; l_idx = 8'h85; l_nxt = 32'h0000_A001; bus.ibus_AVALID = 1; bus.icache_AREADY = 0;
        step();
        l_we = 0; bus.ibus_AVALID = 0; flush = 1;
        step();
        flush = 0;
        chk("rf_busy", 32'(busy), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rf_busy_rst", 32'(busy), 32'd0);
        chk("rf_v_rst", 32'(tlbl[0]), 32'd0);
        chk("rf_avalid_rst", 32'(bus.icache_AVALID), 32'd0);
        model_reset();
        @(posedge clk); #1 rst_n = 1;
        check();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bus.ibus_AVALID   = ($urandom % 10) < 7;
            bus.icache_AREADY = ($urandom % 10) < 7;
            tv = 19'((($urandom % 4) << 7) | ($urandom % 8));
            bus.ibus_AADDR = {tv, 13'($urandom)};
            imme  = ($urandom % 5) != 0;
            rm    = 1'($urandom);
            flush = ($urandom % 40) == 0;
`ifdef NCPU_IMMU_ASID_EN
            asid  = 8'($urandom % 4);
`endif
            l_idx = IW'($urandom); h_idx = IW'($urandom);
            l_we = 0; h_we = 0;
            if ($urandom % 5 == 0) begin
                w  = int'($urandom % NW);
                s  = int'($urandom % 8);
                tv = 19'((($urandom % 4) << 7) | s);
                if ($urandom % 8 == 0) tv[0] = ~tv[0];
                l_nxt = {tv, 12'($urandom), 1'b1};
                l_nxt[9:2] = 8'($urandom % 4);
                if ($urandom % 4 == 0) l_nxt[0] = 1'b0;
                for (int ow = 0; ow < NW; ow++)
                    if (ow != w && ml[ow][s][0] && ml[ow][s][31:13] == l_nxt[31:13]) l_nxt[0] = 1'b0;
                l_we = 1; l_idx = IW'(w * NS + s);
                h_we = 1; h_idx = l_idx; h_nxt = $urandom;
            end else if ($urandom % 10 == 0) begin
                h_we = 1; h_nxt = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
